// File: rtl/arb_mux_n_if.sv
// Handshake bundle for arb_mux_n: N request channels in, one registered channel out.
interface arb_mux_n_if #(
  parameter int WIDTH = 5,
  parameter int N     = 4
);
  localparam int SEL_W = $clog2(N);

  logic [N-1:0]            in_valid;
  logic [N-1:0][WIDTH-1:0] in_data;
  logic [N-1:0]            in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/arb_mux_n.sv
// N-to-1 arbitrating mux with a single registered output stage.
// Policy: ARB_MUX_RR_EN selects round-robin; undefined gives fixed priority (index 0 highest).

module arb_mux_lane #(
  parameter int WIDTH = 5
) (
  input  logic             grant,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] gated
);
  assign gated = grant ? data : '0;
endmodule

module arb_mux_n #(
  parameter int WIDTH = 5,
  parameter int N     = 4
) (
  input  logic        clk,
  input  logic        reset,
  arb_mux_n_if.slave  bus
);
  localparam int SEL_W = $clog2(N);

  logic                    load;
  logic                    xfer;
  logic [SEL_W-1:0]        win;
  logic [N-1:0]            grant;
  logic [N-1:0][WIDTH-1:0] gated;
  logic [WIDTH-1:0]        mux_data;

  // Output stage takes a new item when empty or being drained this cycle.
  assign load = !reset && (!bus.out_valid || bus.out_ready);

`ifdef ARB_MUX_RR_EN
  logic [SEL_W-1:0] ptr;
  int               dist;
  int               best;

  // Winner is the requester at the smallest forward distance from ptr.
  always_comb begin
    win  = '0;
    best = N;
    dist = 0;
    for (int g = 0; g < N; g++) begin
      if (bus.in_valid[g]) begin
        dist = g - int'(ptr);
        if (dist < 0) dist = dist + N;
        if (dist < best) begin
          best = dist;
          win  = SEL_W'(g);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      ptr <= '0;
    else if (xfer)
      ptr <= (win == SEL_W'(N-1)) ? '0 : win + 1'b1;
  end
`else
  // Scan from the top so the lowest requesting index is written last.
  always_comb begin
    win = '0;
    for (int g = N-1; g >= 0; g--) begin
      if (bus.in_valid[g]) win = SEL_W'(g);
    end
  end
`endif

  always_comb begin
    grant = '0;
    if (load && |bus.in_valid) grant[win] = 1'b1;
  end

  assign bus.in_ready = grant;
  assign xfer         = |grant;

  for (genvar g = 0; g < N; g++) begin : g_lane
    arb_mux_lane #(.WIDTH(WIDTH)) u_lane (
      .grant (grant[g]),
      .data  (bus.in_data[g]),
      .gated (gated[g])
    );
  end

  // Grant is one-hot, so an OR of the gated lanes is the selected payload.
  always_comb begin
    mux_data = '0;
    for (int g = 0; g < N; g++) mux_data = mux_data | gated[g];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
    end else if (load) begin
      bus.out_valid <= xfer;
      if (xfer) begin
        bus.out_data <= mux_data;
        bus.out_sel  <= win;
      end
    end
  end
endmodule
